decoder_arbiter: RTL
====================

# decoder_arbiter

Round-robin arbiter that shares one 2-to-4 `Decoder` among four requesters. It picks one requester, drives the decoder select (`sel`) and enable (`en`), and holds that grant until the owner signals `done`, drops its request, or exceeds a hold limit. The block sits in front of the existing `Decoder` datapath. Its decoded one-hot outputs are the grant lines.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum cycles a grant may be held before forced release; legal range 1..255.

Ports:
- `clk`, input, 1: single system clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 4: request per requester; bit i = requester i.
- `done`, input, 4: release strobe per requester; only the bit of the current owner is honoured.
- `sel`, output, 2: decoder select, binary index of the owner (feeds `D1`/`D0`, with `D1` as MSB).
- `en`, output, 1: decoder enable (feeds `E`); high only in GRANT.
- `gnt`, output, 4: one-hot grant, equal to the decoder output `A3..A0`; all zero when `en`=0.
- `busy`, output, 1: high in GRANT and RELEASE.
- `timeout_err`, output, 1: one-cycle pulse on a forced release.

## Operation
- **State machine:** IDLE, GRANT, RELEASE; state is registered.
- **IDLE:**
  - If `req` is non-zero, select a winner by round-robin search starting at `ptr+1` (mod 4) and going upward.
  - Load `sel`=winner, `ptr`=winner, clear `hold_cnt`, then go to GRANT.
  - If `req` is zero, stay in IDLE.
- **GRANT:**
  - `en`=1.
  - Leave to RELEASE when any of these holds:
    - `done[sel]`=1;
    - `req[sel]`=0;
    - `hold_cnt`==`MAX_HOLD`-1, which is a forced release and asserts `timeout_err` on the next cycle.
  - Otherwise, increment `hold_cnt`.
- **RELEASE:**
  - `en`=0 for exactly one cycle, which guarantees no grant overlap.
  - Always return to IDLE.
- **Round-robin pointer `ptr`:**
  - 2 bits, reset to 3 so requester 0 has first priority.
  - Updates only when a grant is issued.
- **`hold_cnt`:** width 8 bits, saturating, cleared on entry to GRANT.
- **Priority of simultaneous release conditions:** `done` or a dropped `req` beats timeout in the same cycle; no error is reported in that case.
- **Ignored inputs:**
  - `done` bits of non-owners are ignored in every state.
  - `done` in IDLE or RELEASE is ignored.
- A request that rises while another requester owns the decoder waits. It is considered at the next IDLE search.
- **Outputs:**
  - `gnt` is produced by the `Decoder` instance: `gnt[i]` = `en` && `sel`==i.
  - `sel` holds its last value outside GRANT; this is harmless because `en`=0 there.

## Timing
- **Reset values** (asserted asynchronously while `rst_n`=0, all outputs forced regardless of clock):
  - state=IDLE, `sel`=0, `en`=0, `gnt`=0000;
  - `busy`=0, `timeout_err`=0, `ptr`=3, `hold_cnt`=0.
- **Grant latency:** `req` sampled high in IDLE at edge t gives `en`/`gnt` high after edge t (visible in cycle t+1).
- **Release latency:** `done[sel]` sampled at edge t gives `en`=0 after t. IDLE follows after t+1. The earliest next grant is visible after t+2.
- **Minimum grant length:** 1 cycle, when `done` is asserted in the first GRANT cycle.
- **Forced release:** with no `done`, `en` stays high for exactly `MAX_HOLD` cycles. `timeout_err` pulses in the first RELEASE cycle.
- **Reset mid-GRANT:** `en`/`gnt` drop immediately and asynchronously. After deassertion, arbitration restarts with `ptr`=3.
- **Reset release:** `rst_n` deassertion is assumed synchronized externally. The first state update happens on the first rising edge with `rst_n`=1.

## Structure
- **Shared package `decoder_arb_pkg`:**
  - state enum: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2;
  - `NREQ`=4;
  - `SEL_W`=2.
- **Sub-module:** one instance of the existing `Decoder` (`D0`=`sel[0]`, `D1`=`sel[1]`, `E`=`en`), which produces `gnt`.
- **Round-robin search:** a combinational function inside the block; no separate module.

## Test plan
- **Reset mid-grant:**
  - Stimulus: `req`=0001 → `gnt`=0001 after 1 cycle; then `rst_n`=0 mid-GRANT.
  - Required: `gnt`=0000 immediately and `ptr`=3 afterwards. Re-request grants requester 0 again.
- **Round-robin rotation:**
  - Stimulus: `req`=1111 held; each owner pulses `done` in its first GRANT cycle.
  - Required: grant order 0,1,2,3,0 with `gnt` pattern 0001,0010,0100,1000,0001. `en` is low for 2 cycles between grants.
- **Timeout:**
  - Stimulus: `MAX_HOLD`=4, `req`=0100 held, no `done`.
  - Required: `gnt`=0100 for exactly 4 cycles, then `timeout_err`=1 for one cycle and `en`=0. Requester 2 is re-granted after 2 cycles.
- **Done and timeout together:**
  - Stimulus: `done[sel]` asserted in the cycle `hold_cnt`==`MAX_HOLD`-1.
  - Required: release occurs, `timeout_err` stays 0.
- **Foreign done and request drop:**
  - Stimulus: owner is 1; `done`=0100 asserted.
  - Required: no effect, grant held. Then `req[1]` drops → release without error, and the next search starts at requester 2.
- **Late request:**
  - Stimulus: `req`=1000 rises while requester 0 owns the decoder.
  - Required: it waits, and is granted 2 cycles after requester 0's `done`.

Source files
------------

// File: rtl/decoder_arb_pkg.sv
// decoder_arb_pkg: shared state encoding and sizes for the decoder arbiter
package decoder_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;
  localparam int NREQ = 4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/Decoder.sv
// Decoder: 2-to-4 decoder with enable, outputs one-hot A3..A0
module Decoder (
  input  logic D0,
  input  logic D1,
  input  logic E,
  output logic A0,
  output logic A1,
  output logic A2,
  output logic A3
);
  assign A0 = E & ~D1 & ~D0;
  assign A1 = E & ~D1 &  D0;
  assign A2 = E &  D1 & ~D0;
  assign A3 = E &  D1 &  D0;
endmodule

// File: rtl/decoder_arbiter.sv
// decoder_arbiter: round-robin arbiter sharing one 2-to-4 Decoder among four requesters
module decoder_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  done,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             timeout_err
);
  state_t state, state_nx;
  logic [SEL_W-1:0] ptr, ptr_nx, sel_nx, win;
  logic [7:0] hold_cnt, hold_nx;
  logic tmo_nx, rel_ok, expire;
  // highest-priority candidate is ptr+1; iterating downward lets the nearest one win
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] idx;
    rr_pick = p;
    for (int k = NREQ; k >= 1; k--) begin
      idx = p + SEL_W'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction
  assign win = rr_pick(req, ptr);
  assign rel_ok = done[sel] || !req[sel];
  assign expire = hold_cnt == 8'(MAX_HOLD - 1);
  assign en = state == GRANT;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    ptr_nx = ptr;
    hold_nx = hold_cnt;
    tmo_nx = 1'b0;
    case (state)
      IDLE: if (|req) begin
        state_nx = GRANT;
        sel_nx = win;
        ptr_nx = win;
        hold_nx = '0;
      end
      GRANT: if (rel_ok || expire) begin
        state_nx = RELEASE;
        tmo_nx = !rel_ok;
      end else hold_nx = hold_cnt + 8'(hold_cnt != 8'hff);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      ptr <= 2'd3;
      hold_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      sel <= sel_nx;
      ptr <= ptr_nx;
      hold_cnt <= hold_nx;
      timeout_err <= tmo_nx;
    end
  Decoder u_dec (
    .D0(sel[0]),
    .D1(sel[1]),
    .E (en),
    .A0(gnt[0]),
    .A1(gnt[1]),
    .A2(gnt[2]),
    .A3(gnt[3])
  );
endmodule
